// File: rtl/multicycle_sequencer_if.sv
// Control-side bundle between the multicycle sequencer and the
// datapath / unified memory port it steers.
interface multicycle_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic [2:0]          opcode;
    logic                eq_out;
    logic                mem_ack;
    logic                resume;
    logic                mem_req;
    logic                mem_we;
    logic                mem_addr_sel;
    logic                ir_we;
    logic                pc_we;
    logic                pc_sel;
    logic                reg_we;
    logic                wb_sel;
    logic                alu_add;
    logic                alu_nand;
    logic                alu_pass1;
    logic                alu_eq;
    logic                halted;
    logic [RETIRE_W-1:0] instr_retired;

    // Sequencer side
    modport slave (
        input  opcode, eq_out, mem_ack, resume,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
               reg_we, wb_sel, alu_add, alu_nand, alu_pass1, alu_eq,
               halted, instr_retired
    );

    // Datapath / memory side
    modport master (
        output opcode, eq_out, mem_ack, resume,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
               reg_we, wb_sel, alu_add, alu_nand, alu_pass1, alu_eq,
               halted, instr_retired
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC core: walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, arbitrates the single
// memory port between fetch and data access, and counts retirements.
module multicycle_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        RST_IDLE = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM      = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_LUI  = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t              state;
    logic [RETIRE_W-1:0] retired_q;
    logic                retire;
    logic                alu_phase;

    // Phase sequencing; memory phases hold until the ack arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_IDLE;
        end else begin
            case (state)
                RST_IDLE: state <= FETCH;
                FETCH:    if (bus.mem_ack) state <= DECODE;
                DECODE:   state <= EXEC;
                EXEC: begin
                    case (bus.opcode)
                        OP_ADD, OP_NAND, OP_LUI: state <= WB;
                        OP_SW, OP_LW:            state <= MEM;
                        OP_HALT:                 state <= HALT;
                        default:                 state <= FETCH;
                    endcase
                end
                MEM:      if (bus.mem_ack) state <= (bus.opcode == OP_LW) ? WB : FETCH;
                WB:       state <= FETCH;
                HALT:     if (bus.resume) state <= FETCH;
                default:  state <= RST_IDLE;
            endcase
        end
    end

    // An instruction retires on the edge that leaves its last phase
    always_comb begin
        retire = 1'b0;
        case (state)
            WB:      retire = 1'b1;
            MEM:     retire = bus.mem_ack && (bus.opcode != OP_LW);
            EXEC:    retire = (bus.opcode == OP_BEQ) || (bus.opcode == OP_NOP) ||
                              (bus.opcode == OP_HALT);
            default: retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.instr_retired = retired_q;

    // Control outputs decoded from phase and opcode; reset forces IDLE so they drop at once
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_sel       = 1'b0;
        bus.reg_we       = 1'b0;
        bus.wb_sel       = 1'b0;
        bus.halted       = 1'b0;
        alu_phase        = (state == EXEC) || (state == MEM) || (state == WB);
        case (state)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ack;
                bus.pc_we   = bus.mem_ack;
            end
            EXEC: begin
                if (bus.opcode == OP_BEQ) begin
                    bus.pc_we  = bus.eq_out;
                    bus.pc_sel = 1'b1;
                end
            end
            MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (bus.opcode == OP_SW);
            end
            WB: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = (bus.opcode == OP_LW);
            end
            HALT:    bus.halted = 1'b1;
            default: ;
        endcase
        bus.alu_add   = alu_phase && ((bus.opcode == OP_ADD) || (bus.opcode == OP_SW) ||
                                      (bus.opcode == OP_LW));
        bus.alu_nand  = alu_phase && (bus.opcode == OP_NAND);
        bus.alu_pass1 = alu_phase && (bus.opcode == OP_LUI);
        bus.alu_eq    = alu_phase && (bus.opcode == OP_BEQ);
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle control pattern; one compare
// process checks every cycle, plus literal pins and a narrow-counter wrap run.
module tb_multicycle_sequencer;
    localparam logic [2:0] ADD = 3'b000, NAND = 3'b001, LUI = 3'b010, BEQ = 3'b011;
    localparam logic [2:0] SW = 3'b100, LW = 3'b101, NOP = 3'b110, HLT = 3'b111;

    logic clk, rst, rst4;
    multicycle_sequencer_if #(.RETIRE_W(16)) bus();
    multicycle_sequencer_if #(.RETIRE_W(4))  bus4();

    multicycle_sequencer #(.RETIRE_W(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    multicycle_sequencer #(.RETIRE_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    int          n_total = 0;
    int          n_bad   = 0;
    logic [12:0] exp_out;
    logic [15:0] exp_ret;
    logic [15:0] ret_m;
    logic        chk_en;
    logic [12:0] act;

    assign act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
                  bus.pc_sel, bus.reg_we, bus.wb_sel, bus.alu_add, bus.alu_nand,
                  bus.alu_pass1, bus.alu_eq, bus.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Single compare process: DUT against the model, once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("outs", 32'(act), 32'(exp_out));
            check("retired", 32'(bus.instr_retired), 32'(exp_ret));
        end
    end

    function automatic logic [12:0] mk(input logic req, we, asel, irwe, pcwe, pcsel,
                                       regwe, wbsel, input logic [3:0] alu, input logic hlt);
        return {req, we, asel, irwe, pcwe, pcsel, regwe, wbsel, alu, hlt};
    endfunction

    // {add, nand, pass1, eq} required for each opcode while the ALU is in use
    function automatic logic [3:0] alu_of(input logic [2:0] op);
        case (op)
            ADD, SW, LW: return 4'b1000;
            NAND:        return 4'b0100;
            LUI:         return 4'b0010;
            BEQ:         return 4'b0001;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input logic [2:0] op, input logic ack, eq, res, input logic [12:0] e);
        @(posedge clk);
        #1;
        bus.opcode  = op;
        bus.mem_ack = ack;
        bus.eq_out  = eq;
        bus.resume  = res;
        exp_out     = e;
        exp_ret     = ret_m;
        chk_en      = 1'b1;
    endtask

    // One instruction as a cycle schedule; noise on inputs that must be ignored
    task automatic run_instr(input logic [2:0] op, input int fw, input int mw,
                             input logic eq, input int hold, output int ncyc);
        logic [3:0] alu;
        alu  = alu_of(op);
        ncyc = 0;
        for (int i = 0; i < fw; i++) begin
            cyc(3'($urandom), 1'b0, rb(), rb(), mk(1,0,0,0,0,0,0,0,4'b0,0));
            ncyc++;
        end
        cyc(3'($urandom), 1'b1, rb(), rb(), mk(1,0,0,1,1,0,0,0,4'b0,0));
        ncyc++;
        cyc(op, rb(), rb(), rb(), 13'd0);
        ncyc++;
        if (op == BEQ) cyc(op, rb(), eq, rb(), mk(0,0,0,0,eq,1,0,0,alu,0));
        else           cyc(op, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,alu,0));
        ncyc++;
        if (op == BEQ || op == NOP || op == HLT) ret_m++;
        if (op == HLT) begin
            for (int h = 0; h < hold; h++) begin
                cyc(op, rb(), rb(), logic'(h == hold - 1), mk(0,0,0,0,0,0,0,0,4'b0,1));
                ncyc++;
            end
        end
        if (op == SW || op == LW) begin
            for (int w = 0; w <= mw; w++) begin
                cyc(op, logic'(w == mw), rb(), rb(), mk(1,logic'(op == SW),1,0,0,0,0,0,alu,0));
                ncyc++;
            end
            if (op == SW) ret_m++;
        end
        if (op == ADD || op == NAND || op == LUI || op == LW) begin
            cyc(op, rb(), rb(), rb(), mk(0,0,0,0,0,0,1,logic'(op == LW),alu,0));
            ncyc++;
            ret_m++;
        end
    endtask

    // Asynchronous reset: outputs must drop before any clock edge
    task automatic reset_main();
        chk_en      = 1'b0;
        bus.mem_ack = 1'b0;
        bus.resume  = 1'b0;
        bus.eq_out  = 1'b0;
        rst         = 1'b1;
        #1;
        check("rst_outs", 32'(act), 32'd0);
        check("rst_ret", 32'(bus.instr_retired), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ret_m   = '0;
        exp_out = '0;
        exp_ret = '0;
        chk_en  = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b0;  rst4 = 1'b0;  chk_en = 1'b0;
        ret_m = '0;  exp_out = '0;  exp_ret = '0;
        bus.opcode = NOP;  bus.mem_ack = 1'b0;  bus.eq_out = 1'b0;  bus.resume = 1'b0;
        bus4.opcode = NOP; bus4.mem_ack = 1'b1; bus4.eq_out = 1'b0; bus4.resume = 1'b0;
        #2;
        rst4 = 1'b1;
        reset_main();

        run_instr(ADD, 0, 0, 1'b0, 1, n);
        check("add_cycles", 32'(n), 32'd4);
        check("add_ret_model", 32'(ret_m), 32'd1);
        run_instr(LW, 2, 1, 1'b0, 1, n);
        check("lw_wait_cycles", 32'(n), 32'd8);
        run_instr(BEQ, 0, 0, 1'b1, 1, n);
        check("beq_taken_cycles", 32'(n), 32'd3);
        run_instr(BEQ, 0, 0, 1'b0, 1, n);
        check("beq_not_cycles", 32'(n), 32'd3);
        run_instr(SW, 0, 0, 1'b0, 1, n);
        check("sw_cycles", 32'(n), 32'd4);
        run_instr(HLT, 0, 0, 1'b0, 5, n);
        check("halt_cycles", 32'(n), 32'd8);
        check("directed_retired", 32'(bus.instr_retired), 32'd6);

        // Reset pulsed while an LW data access is waiting
        cyc(NOP, 1'b1, 1'b0, 1'b0, mk(1,0,0,1,1,0,0,0,4'b0,0));
        cyc(LW, 1'b0, 1'b0, 1'b0, 13'd0);
        cyc(LW, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,4'b1000,0));
        cyc(LW, 1'b0, 1'b0, 1'b0, mk(1,0,1,0,0,0,0,0,4'b1000,0));
        @(posedge clk);
        #1;
        reset_main();

        repeat (250) begin
            run_instr(3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      rb(), int'($urandom_range(1, 4)), n);
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        // 4-bit counter: zero-wait NOPs take 3 cycles each
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        repeat (46) @(posedge clk);
        #1;
        check("w4_after15", 32'(bus4.instr_retired), 32'd15);
        repeat (3) @(posedge clk);
        #1;
        check("w4_wrap16", 32'(bus4.instr_retired), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("w4_after17", 32'(bus4.instr_retired), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
